g31_sha256_mm_engine: RTL

- Parametrised SHA-256 compression engine with an Avalon-MM slave register interface and an interrupt line.
- Sits inside the g31 SHA256 Qsys system on the HPS lightweight bridge and replaces software hashing on the ARM.
- Software writes a 512-bit padded block, starts the engine, then reads the 256-bit running digest.
- Generalises the fixed system with configurable rounds-per-cycle, multi-block chaining and a sticky-done interrupt.

---
 rtl/g31_sha256_pkg.sv | 60 ++++++
 rtl/g31_sha256_round.sv | 20 ++
 rtl/g31_sha256_mm_engine.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/g31_sha256_pkg.sv
// Shared constants, register map, FSM encoding and FIPS 180-4 helper functions
// for the g31 SHA-256 memory-mapped engine.
package g31_sha256_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_ROUND = 2'd2,
      ST_FINAL = 2'd3
   } state_e;

   localparam logic [4:0] ADDR_CTRL   = 5'h10;
   localparam logic [4:0] ADDR_STATUS = 5'h11;
   localparam logic [4:0] ADDR_H_BASE = 5'h18;

   localparam logic [31:0] K [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [31:0] IV [0:7] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/g31_sha256_round.sv
// One combinational SHA-256 compression round; index 0 of the state is a, 7 is h.
module g31_sha256_round
   import g31_sha256_pkg::*;
(
   input  logic [7:0][31:0] state_i,
   input  logic [31:0]      k_i,
   input  logic [31:0]      w_i,
   output logic [7:0][31:0] state_o
);

   logic [31:0] t1_s;
   logic [31:0] t2_s;

   assign t1_s = state_i[7] + bsig1(state_i[4]) + ch(state_i[4], state_i[5], state_i[6]) + k_i + w_i;
   assign t2_s = bsig0(state_i[0]) + maj(state_i[0], state_i[1], state_i[2]);

   assign state_o = {state_i[6], state_i[5], state_i[4], state_i[3] + t1_s,
                     state_i[2], state_i[1], state_i[0], t1_s + t2_s};

endmodule

// File: rtl/g31_sha256_mm_engine.sv
// SHA-256 compression engine behind an Avalon-MM slave: message/digest registers,
// control FSM, sliding schedule window and a chain of unrolled rounds.
module g31_sha256_mm_engine
   import g31_sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int ADDR_W           = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   output logic [31:0]       avs_readdata,
   output logic              irq
);

   localparam int         RPC      = ROUNDS_PER_CYCLE;
   localparam logic [5:0] LAST_CNT = 6'(64 / RPC - 1);

   state_e           state_q;
   logic [31:0]      msg_q [0:15];
   logic [7:0][31:0] h_q;
   logic [7:0][31:0] work_q;
   logic [15:0][31:0] win_q;
   logic [15:0][31:0] win_d;
   logic [5:0]       cnt_q;
   logic             busy_q;
   logic             done_q;
   logic             irq_en_q;
   logic             init_q;
   logic [31:0]      rdata_d;
   logic [7:0][31:0] work_d;
   logic [31:0]      ext_s [0:15+RPC];

   logic is_msg_s, is_h_s, wr_ctrl_s, wr_stat_s, start_s;

   assign is_msg_s  = (avs_address >> 4) == ADDR_W'(5'd0);
   assign is_h_s    = (avs_address >> 3) == ADDR_W'(5'd3);
   assign wr_ctrl_s = avs_write && (avs_address == ADDR_W'(ADDR_CTRL));
   assign wr_stat_s = avs_write && (avs_address == ADDR_W'(ADDR_STATUS));
   assign start_s   = wr_ctrl_s && avs_writedata[0] && (state_q == ST_IDLE);

   assign irq = done_q & irq_en_q;

   // Round chain: each stage feeds the next; K index follows the global round number.
   for (genvar g = 0; g < RPC; g++) begin : g_round
      logic [7:0][31:0] in_s;
      logic [7:0][31:0] out_s;
      logic [5:0]       kidx_s;
      if (g == 0) begin : g_first
         assign in_s = work_q;
      end else begin : g_next
         assign in_s = g_round[g-1].out_s;
      end
      assign kidx_s = 6'(int'(cnt_q) * RPC + g);
      g31_sha256_round u_round (
         .state_i (in_s),
         .k_i     (K[kidx_s]),
         .w_i     (win_q[g]),
         .state_o (out_s)
      );
   end

   assign work_d = g_round[RPC-1].out_s;

   // Message schedule: extend the window by RPC words, then slide it.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         ext_s[i] = win_q[i];
      end
      for (int j = 0; j < RPC; j++) begin
         ext_s[16+j] = ssig1(ext_s[14+j]) + ext_s[9+j] + ssig0(ext_s[1+j]) + ext_s[j];
      end
      for (int i = 0; i < 16; i++) begin
         win_d[i] = ext_s[i+RPC];
      end
   end

   // Read-data mux; unmapped addresses return zero.
   always_comb begin
      rdata_d = 32'h0;
      if (!avs_read) begin
         rdata_d = 32'h0;
      end else if (is_msg_s) begin
         rdata_d = msg_q[avs_address[3:0]];
      end else if (avs_address == ADDR_W'(ADDR_CTRL)) begin
         rdata_d = {29'h0, irq_en_q, 2'b00};
      end else if (avs_address == ADDR_W'(ADDR_STATUS)) begin
         rdata_d = {30'h0, done_q, busy_q};
      end else if (is_h_s) begin
         rdata_d = h_q[avs_address[2:0]];
      end else begin
         rdata_d = 32'h0;
      end
   end

   // Control FSM with register file; FINAL's DONE set is placed after the W1C so it wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         h_q          <= '0;
         work_q       <= '0;
         win_q        <= '0;
         cnt_q        <= 6'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         irq_en_q     <= 1'b0;
         init_q       <= 1'b0;
         avs_readdata <= 32'h0;
         for (int i = 0; i < 16; i++) begin
            msg_q[i] <= 32'h0;
         end
      end else begin
         avs_readdata <= rdata_d;
         if (avs_write && is_msg_s) begin
            msg_q[avs_address[3:0]] <= avs_writedata;
         end
         if (wr_ctrl_s) begin
            irq_en_q <= avs_writedata[2];
         end
         if (wr_stat_s && avs_writedata[1]) begin
            done_q <= 1'b0;
         end
         case (state_q)
            ST_IDLE: begin
               if (start_s) begin
                  state_q <= ST_LOAD;
                  init_q  <= avs_writedata[1];
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
               end
            end
            ST_LOAD: begin
               for (int i = 0; i < 8; i++) begin
                  if (init_q) begin
                     h_q[i] <= IV[i];
                  end
                  work_q[i] <= init_q ? IV[i] : h_q[i];
               end
               for (int i = 0; i < 16; i++) begin
                  win_q[i] <= msg_q[i];
               end
               cnt_q   <= 6'd0;
               state_q <= ST_ROUND;
            end
            ST_ROUND: begin
               work_q <= work_d;
               win_q  <= win_d;
               cnt_q  <= cnt_q + 6'd1;
               if (cnt_q == LAST_CNT) begin
                  state_q <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               for (int i = 0; i < 8; i++) begin
                  h_q[i] <= h_q[i] + work_q[i];
               end
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
